// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
//
// Iterative 32x32 unsigned multiply / divide sequencer sitting in front of an
// external combinational 74S181-style ALU. Each STEP cycle this block drives
// the ALU function select and operands, then folds the 33-bit ALU result back
// into its HI/LO working registers. A multiply is a shift-add loop; a divide
// is a restoring shift-subtract loop. Both take 32 steps, followed by a single
// FINISH cycle that pulses done.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous active-high reset, returns to IDLE
//   start      in   1      begin an operation (only honoured in IDLE)
//   op         in   1      0 = multiply, 1 = divide (sampled with start)
//   opa        in   WIDTH  multiplicand / dividend
//   opb        in   WIDTH  multiplier / divisor
//   alu_m      out  WIDTH  ALU A-port (m)
//   alu_a      out  WIDTH  ALU B-port (a)
//   aluf       out  4      ALU S select
//   alumode    out  1      ALU M select, tied to arithmetic (0)
//   cin0       out  1      ALU carry in, active-high
//   alu        in   WIDTH+1 ALU result, top bit is the signed extension slice
//   busy       out  1      high while in STEP or FINISH
//   done       out  1      one-cycle pulse, results valid
//   div_zero   out  1      divide-by-zero flag, valid with done
//   result_hi  out  WIDTH  product[63:32] / remainder
//   result_lo  out  WIDTH  product[31:0]  / quotient
// -----------------------------------------------------------------------------
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] alu_m,
  output logic [WIDTH-1:0] alu_a,
  output logic [3:0]       aluf,
  output logic             alumode,
  output logic             cin0,
  input  logic [WIDTH:0]   alu,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [3:0]       ALUF_ADD = 4'b1001;
  localparam logic [3:0]       ALUF_SUB = 4'b0110;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             dz_q, dz_d;

  logic             carry_out;
  logic             div_ge;

  // ALU drive. Outside STEP the ALU is parked on ADD with zero operands so
  // it produces a quiet, predictable result. In STEP a multiply adds the
  // multiplicand into HI when the current multiplier bit (LO[0]) is set; a
  // divide subtracts the divisor from HI shifted left by one with the next
  // dividend bit (LO[31]) brought in at the bottom.
  always_comb begin
    alu_m = '0;
    alu_a = '0;
    aluf  = ALUF_ADD;
    cin0  = 1'b0;
    if (state == S_STEP) begin
      if (op_q) begin
        alu_m = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        alu_a = opnd_q;
        aluf  = ALUF_SUB;
        cin0  = 1'b1;
      end else begin
        alu_m = hi_q;
        alu_a = lo_q[0] ? opnd_q : '0;
      end
    end
  end

  assign alumode = 1'b0;

  // The ALU's top bit is a sign extension, not a carry. Undoing the sign
  // extension of both operands recovers the true unsigned carry out of bit
  // WIDTH-1. For subtract the B operand is effectively inverted, and a
  // carry of 1 means the subtraction did not borrow.
  always_comb begin
    if (op_q) begin
      carry_out = alu[WIDTH] ^ alu_m[WIDTH-1] ^ ~alu_a[WIDTH-1];
    end else begin
      carry_out = alu[WIDTH] ^ alu_m[WIDTH-1] ^ alu_a[WIDTH-1];
    end
  end

  // The partial remainder shifted into alu_m is really WIDTH+1 bits wide;
  // HI[31] is the bit that fell off the top. If it was set the shifted value
  // is certainly >= the divisor even though the WIDTH-bit compare says no.
  assign div_ge = hi_q[WIDTH-1] | carry_out;

  // Next-state and register update logic for the sequencer.
  always_comb begin
    state_next = state;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dz_d       = dz_q;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          dz_d  = 1'b0;
          cnt_d = '0;
          if (!op) begin
            hi_d       = '0;
            lo_d       = opb;
            opnd_d     = opa;
            state_next = S_STEP;
          end else if (opb != '0) begin
            hi_d       = '0;
            lo_d       = opa;
            opnd_d     = opb;
            state_next = S_STEP;
          end else begin
            // Divide by zero skips the iteration entirely and reports the
            // dividend as remainder with an all-ones quotient.
            hi_d       = opa;
            lo_d       = '1;
            opnd_d     = '0;
            dz_d       = 1'b1;
            state_next = S_FINISH;
          end
        end
      end

      S_STEP: begin
        if (op_q) begin
          hi_d = div_ge ? alu[WIDTH-1:0] : alu_m;
          lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
          // The sum is WIDTH+1 bits with the carry on top; shifting the whole
          // thing right by one moves the sum's low bit into the product's
          // low half while the multiplier bits drain out of LO.
          hi_d = {carry_out, alu[WIDTH-1:1]};
          lo_d = {alu[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_next = S_FINISH;
        end
      end

      S_FINISH: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and working registers. An asynchronous reset aborts any
  // operation in flight and clears every register, so the results read
  // back as zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      op_q   <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      state  <= state_next;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      dz_q   <= dz_d;
    end
  end

  // HI/LO are not touched in IDLE or FINISH, so they double as the result
  // registers and hold their values until the next accepted start.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);
  assign div_zero  = dz_q;
  assign result_hi = hi_q;
  assign result_lo = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_seq
//
// Bench for alu_muldiv_seq. Models the external ALU behaviourally, then runs
// directed corner cases followed by random multiply/divide operations. The
// expected results come from plain 64-bit multiplication and division.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] alu_m;
  logic [31:0] alu_a;
  logic [3:0]  aluf;
  logic        alumode;
  logic        cin0;
  logic [32:0] alu;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  int          n_checks;
  int          n_fail;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic        exp_dz;
  int          exp_lat;

  alu_muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .alu_m     (alu_m),
    .alu_a     (alu_a),
    .aluf      (aluf),
    .alumode   (alumode),
    .cin0      (cin0),
    .alu       (alu),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .result_hi (result_hi),
    .result_lo (result_lo)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 181-style ALU in arithmetic mode: S=0110 is m - a - 1 + cin,
  // anything else is treated as m + a + cin. Both operands are sign extended
  // to 33 bits, which is what the extension slice produces.
  always_comb begin
    logic [32:0] m_ext;
    logic [32:0] a_ext;
    m_ext = {alu_m[31], alu_m};
    a_ext = {alu_a[31], alu_a};
    if (aluf == 4'b0110) begin
      alu = m_ext + ~a_ext + 33'(cin0);
    end else begin
      alu = m_ext + a_ext + 33'(cin0);
    end
  end

  // One comparison point: counts it, and on mismatch counts the failure.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference model: plain arithmetic on the whole operands.
  task automatic refModel(input logic o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    if (!o) begin
      prod    = {32'd0, a} * {32'd0, b};
      exp_hi  = prod[63:32];
      exp_lo  = prod[31:0];
      exp_dz  = 1'b0;
      exp_lat = 32;
    end else if (b == 32'd0) begin
      exp_hi  = a;
      exp_lo  = 32'hFFFF_FFFF;
      exp_dz  = 1'b1;
      exp_lat = 0;
    end else begin
      exp_hi  = a % b;
      exp_lo  = a / b;
      exp_dz  = 1'b0;
      exp_lat = 32;
    end
  endtask

  // Presents one start cycle and computes the expected outcome. Afterwards
  // the operand inputs are scrambled since they are don't-care.
  task automatic applyStimulus(input logic o, input logic [31:0] a, input logic [31:0] b);
    refModel(o, a, b);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 1'($urandom);
    opa   = $urandom;
    opb   = $urandom;
  endtask

  // Waits (bounded) for done, checking latency, busy continuity and results,
  // then checks the cycle after done: idle, no done, results held.
  task automatic waitAndCheck(input string tag, input int lat_expected);
    bit seen;
    bit busy_ok;
    int lat;
    seen    = 1'b0;
    busy_ok = 1'b1;
    lat     = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(lat_expected));
    checkOutput({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    checkOutput({tag, "_busy_fin"}, 64'(busy), 64'd1);
    checkOutput({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
    checkOutput({tag, "_lo"}, 64'(result_lo), 64'(exp_lo));
    checkOutput({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    checkOutput({tag, "_hold"}, {result_hi, result_lo}, {exp_hi, exp_lo});
  endtask

  task automatic runOp(input string tag, input logic o, input logic [31:0] a,
                       input logic [31:0] b);
    applyStimulus(o, a, b);
    waitAndCheck(tag, exp_lat);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_dz"}, 64'(div_zero), 64'd0);
    checkOutput({tag, "_res"}, {result_hi, result_lo}, 64'd0);
    checkOutput({tag, "_alu_ops"}, {alu_m, alu_a}, 64'd0);
    checkOutput({tag, "_alu_ctl"}, {58'd0, aluf, alumode, cin0}, {58'd0, 4'b1001, 1'b0, 1'b0});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ro;
    logic [31:0] keep_hi;
    logic [31:0] keep_lo;
    bit          busy_gap;
    bit          done_seen;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    op       = 1'b0;
    opa      = '0;
    opb      = '0;

    // Reset state.
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("post_reset");

    // Directed corner cases; each start lands in the cycle after the
    // previous done, so these also exercise back-to-back acceptance.
    runOp("mul_max",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("mul_max_const", {exp_hi, exp_lo}, 64'hFFFF_FFFE_0000_0001);
    runOp("mul_zero", 1'b0, 32'h1234_5678, 32'h0000_0000);
    runOp("mul_3x5",  1'b0, 32'd3, 32'd5);
    runOp("div_100_7", 1'b1, 32'd100, 32'd7);
    runOp("div_by_1", 1'b1, 32'hFFFF_FFFF, 32'd1);
    runOp("div_zero", 1'b1, 32'h0000_1234, 32'd0);
    runOp("div_after_dz", 1'b1, 32'h8000_0001, 32'h8000_0000);
    checkOutput("dz_cleared", 64'(div_zero), 64'd0);
    runOp("div_small_big", 1'b1, 32'd5, 32'hFFFF_FFFF);

    // Start pulsed mid-operation must be ignored.
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h0000_1001);
    keep_hi  = exp_hi;
    keep_lo  = exp_lo;
    busy_gap = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_gap = 1'b1;
    end
    start = 1'b1;
    op    = 1'b1;
    opa   = 32'h0000_0042;
    opb   = 32'h0000_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ign_busy_early", 64'(busy_gap), 64'd0);
    exp_hi = keep_hi;
    exp_lo = keep_lo;
    exp_dz = 1'b0;
    waitAndCheck("ignore_start", 28);

    // Reset in the middle of an operation aborts it.
    applyStimulus(1'b0, 32'h0F0F_0F0F, 32'h7777_7777);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checkIdleOutputs("abort");
    @(negedge clk);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen = 1'b1;
    end
    checkOutput("abort_no_done", 64'(done_seen), 64'd0);
    checkIdleOutputs("abort_after");
    runOp("after_abort", 1'b1, 32'd1000, 32'd33);

    // Random operations against the arithmetic model.
    for (int n = 0; n < 24; n++) begin
      ro = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 255);
        2:       rb = ra >> $urandom_range(0, 31);
        3:       rb = (n % 6 == 0) ? 32'd0 : $urandom;
        default: rb = ra | 32'h8000_0000;
      endcase
      runOp($sformatf("rand%0d", n), ro, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
